// File: rtl/move_step_scheduler.sv
// rtl/move_step_scheduler.sv - step-rate move scheduler for the shared player/enemy move datapath
//
// Purpose: opens a movement window every FRAMES_PER_STEP frame ticks, samples
// the player and enemy one-hot direction requests at window open, arbitrates
// round-robin between them and issues up to two one-cycle move commands per
// window. Also tracks the player knockback cooldown and recovers from a
// datapath that never returns mv_done.
//
// Optional feature: define MOVE_STATS_EN to implement the move_count counter;
// when undefined move_count is tied to zero.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   frame_tick   one-cycle pulse per video frame
//   p_dir/e_dir  one-hot {up,down,left,right} requests; non-one-hot = none
//   mv_dir       one-cycle registered command to the datapath
//   mv_sel       owner of the current command (0 player, 1 enemy)
//   mv_done      datapath completion pulse
//   mv_collide   enemy-collision flag, valid with mv_done
//   hit          one-cycle pulse after a colliding player command
//   cooldown     player knockback cooldown active
//   timeout_err  sticky done-timeout flag
//   move_count   completed command count
module move_step_scheduler #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int COOLDOWN_STEPS  = 8,
    parameter int DONE_TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [3:0]  p_dir,
    input  logic [3:0]  e_dir,
    output logic [3:0]  mv_dir,
    output logic        mv_sel,
    input  logic        mv_done,
    input  logic        mv_collide,
    output logic        hit,
    output logic        cooldown,
    output logic        timeout_err,
    output logic [15:0] move_count
);

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, NEXT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [7:0]  cd_q, cd_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        rr_last_q, rr_last_d;
    logic        p_ok_q, p_ok_d;
    logic        e_ok_q, e_ok_d;
    logic [3:0]  p_cap_q, p_cap_d;
    logic [3:0]  e_cap_q, e_cap_d;
    logic        pend_q, pend_d;
    logic        pend_sel_q, pend_sel_d;
    logic [3:0]  mv_dir_q, mv_dir_d;
    logic        mv_sel_q, mv_sel_d;
    logic        hit_q, hit_d;
    logic        terr_q, terr_d;
    logic        win;
    logic        grant;
`ifdef MOVE_STATS_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        cd_d       = cd_q;
        wcnt_d     = wcnt_q;
        rr_last_d  = rr_last_q;
        p_ok_d     = p_ok_q;
        e_ok_d     = e_ok_q;
        p_cap_d    = p_cap_q;
        e_cap_d    = e_cap_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        mv_dir_d   = 4'd0;
        mv_sel_d   = mv_sel_q;
        hit_d      = 1'b0;
        terr_d     = terr_q;
        win        = 1'b0;
        grant      = 1'b0;
`ifdef MOVE_STATS_EN
        cnt_d      = cnt_q;
`endif

        // Frame counter keeps running in every state; windows outside IDLE are dropped.
        if (frame_tick) begin
            if (fcnt_q == 8'(FRAMES_PER_STEP - 1)) begin
                fcnt_d = 8'd0;
                win    = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end

        if (win && (cd_q != 8'd0)) begin
            cd_d = cd_q - 8'd1;
        end

        case (state_q)
            IDLE: begin
                // Eligibility is frozen at window open, using the cooldown value
                // before this window's decrement.
                if (win) begin
                    p_ok_d  = is_onehot(p_dir) && (cd_q == 8'd0);
                    e_ok_d  = is_onehot(e_dir);
                    p_cap_d = p_dir;
                    e_cap_d = e_dir;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!p_ok_q && !e_ok_q) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    grant = (p_ok_q && e_ok_q) ? ~rr_last_q : e_ok_q;
                    if (p_ok_q && e_ok_q) begin
                        rr_last_d = grant;
                    end
                    pend_d     = p_ok_q && e_ok_q;
                    pend_sel_d = ~grant;
                    mv_dir_d   = grant ? e_cap_q : p_cap_q;
                    mv_sel_d   = grant;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_d  = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mv_done) begin
`ifdef MOVE_STATS_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                    if (!mv_sel_q && mv_collide) begin
                        hit_d = 1'b1;
                        // Overrides any decrement from a window in this cycle.
                        if (COOLDOWN_STEPS != 0) begin
                            cd_d = 8'(COOLDOWN_STEPS);
                        end
                    end
                    state_d = NEXT;
                end else if (wcnt_q == 16'(DONE_TIMEOUT - 2)) begin
                    // wcnt is 0 one cycle after issue, so this edge lands
                    // DONE_TIMEOUT cycles after mv_dir was driven.
                    terr_d  = 1'b1;
                    state_d = NEXT;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            NEXT: begin
                if (pend_q) begin
                    pend_d   = 1'b0;
                    mv_dir_d = pend_sel_q ? e_cap_q : p_cap_q;
                    mv_sel_d = pend_sel_q;
                    state_d  = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fcnt_q     <= 8'd0;
            cd_q       <= 8'd0;
            wcnt_q     <= 16'd0;
            rr_last_q  <= 1'b1;
            p_ok_q     <= 1'b0;
            e_ok_q     <= 1'b0;
            p_cap_q    <= 4'd0;
            e_cap_q    <= 4'd0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            mv_dir_q   <= 4'd0;
            mv_sel_q   <= 1'b0;
            hit_q      <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            cd_q       <= cd_d;
            wcnt_q     <= wcnt_d;
            rr_last_q  <= rr_last_d;
            p_ok_q     <= p_ok_d;
            e_ok_q     <= e_ok_d;
            p_cap_q    <= p_cap_d;
            e_cap_q    <= e_cap_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            mv_dir_q   <= mv_dir_d;
            mv_sel_q   <= mv_sel_d;
            hit_q      <= hit_d;
            terr_q     <= terr_d;
        end
    end

`ifdef MOVE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign move_count = cnt_q;
`else
    assign move_count = 16'd0;
`endif

    assign mv_dir      = mv_dir_q;
    assign mv_sel      = mv_sel_q;
    assign hit         = hit_q;
    assign cooldown    = (cd_q != 8'd0);
    assign timeout_err = terr_q;

endmodule
